// File: rtl/calc_regfile_alu_seq_pkg.sv
// calc_pkg: shared constants for the register-file calculator core.
//   - OP_* : 3-bit opcodes presented on the op port when start is accepted.
//   - ST_* : controller state encoding (idle vs. iterative multiply running).
package calc_pkg;

  localparam logic [2:0] OP_INIT = 3'b000;
  localparam logic [2:0] OP_LDI  = 3'b001;
  localparam logic [2:0] OP_MOV  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_POW2 = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

endpackage

// File: rtl/calc_regfile_alu_seq_if.sv
// calc_regfile_alu_seq_if: instruction issue / status bundle for the calculator core.
//   start, op, dst, src, imm : issue request from the controller (master drives)
//   busy, done, ovf, zero, err : handshake and status flags (slave drives)
//   regs : flattened register file, R[i] at bits [i*WIDTH +: WIDTH]
interface calc_regfile_alu_seq_if #(
  parameter int WIDTH = 5,
  parameter int NREGS = 4
);
  localparam int IDXW = $clog2(NREGS);

  logic                   start;
  logic [2:0]             op;
  logic [IDXW-1:0]        dst;
  logic [IDXW-1:0]        src;
  logic [WIDTH-1:0]       imm;
  logic                   busy;
  logic                   done;
  logic                   ovf;
  logic                   zero;
  logic                   err;
  logic [NREGS*WIDTH-1:0] regs;

  modport master (
    output start, op, dst, src, imm,
    input  busy, done, ovf, zero, err, regs
  );

  modport slave (
    input  start, op, dst, src, imm,
    output busy, done, ovf, zero, err, regs
  );
endinterface

// File: rtl/calc_regfile_alu_seq_mul.sv
// calc_seq_mul: iterative unsigned shift-add multiplier, one multiplier bit per cycle.
//   clk, rst_n : clock, asynchronous active-low reset (aborts a running multiply)
//   go         : load operands a, b and start (ignored by design while busy)
//   busy       : multiply in progress
//   done       : high in the last busy cycle, when prod already holds the final product
//   prod       : 2*WIDTH-bit product
module calc_seq_mul #(
  parameter int WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);
  localparam int CNTW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNTW-1:0]    cnt;
  logic               running;

  // The first partial product is folded into the load cycle, so the remaining
  // WIDTH-1 bits finish in time for the owner to write on the WIDTH-th edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (go) begin
      acc     <= b[0] ? (2*WIDTH)'(a) : '0;
      mcand   <= (2*WIDTH)'(a) << 1;
      mplier  <= b >> 1;
      cnt     <= CNTW'(WIDTH - 1);
      running <= 1'b1;
    end else if (running) begin
      if (cnt != '0) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CNTW'(1);
      end else begin
        running <= 1'b0;
      end
    end
  end

  assign busy = running;
  assign done = running && (cnt == '0);
  assign prod = acc;
endmodule

// File: rtl/calc_regfile_alu_seq.sv
// calc_regfile_alu_seq: register-file calculator core (NREGS x WIDTH registers).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of calc_regfile_alu_seq_if (start/op/dst/src/imm in;
//                busy/done/ovf/zero/err/regs out)
// Single-cycle ops complete on the accepting edge; MUL runs on calc_seq_mul and
// writes its result WIDTH edges after acceptance.
module calc_regfile_alu_seq
  import calc_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int NREGS = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  calc_regfile_alu_seq_if.slave bus
);
  localparam int IDXW = $clog2(NREGS);

  logic [WIDTH-1:0]   r [NREGS];
  logic [0:0]         state;
  logic [IDXW-1:0]    mul_dst;
  logic               done_q, ovf_q, zero_q, err_q;
  logic               accept, bad_idx, mul_go;
  logic               mul_busy, mul_done;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   op_a, op_b, res;
  logic               res_ovf;

  assign op_a    = r[bus.dst];
  assign op_b    = r[bus.src];
  assign bad_idx = (32'(bus.dst) >= NREGS) || (32'(bus.src) >= NREGS);
  assign accept  = bus.start && (state == ST_IDLE) && !mul_busy;
  assign mul_go  = accept && !bad_idx && (bus.op == OP_MUL);

  calc_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk  (clk),
    .rst_n(rst_n),
    .go   (mul_go),
    .a    (op_a),
    .b    (op_b),
    .busy (mul_busy),
    .done (mul_done),
    .prod (prod)
  );

  // Result and overflow of the single-destination, single-cycle ops.
  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    case (bus.op)
      OP_LDI: res = bus.imm;
      OP_MOV: res = op_b;
      OP_ADD: {res_ovf, res} = {1'b0, op_a} + {1'b0, op_b};
      OP_SUB: begin
        res     = op_a - op_b;
        res_ovf = (op_a < op_b);
      end
      OP_POW2: begin
        if (32'(op_b) < WIDTH) res = WIDTH'(1) << op_b;
        else res_ovf = 1'b1;
      end
      default: res = '0;
    endcase
  end

  // Register file, flags and controller. err is only updated at completion so
  // flags stay stable for the whole duration of a multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r[i] <= '0;
      state   <= ST_IDLE;
      mul_dst <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == ST_IDLE) begin
        if (accept) begin
          if (bad_idx) begin
            err_q  <= 1'b1;
            done_q <= 1'b1;
          end else begin
            case (bus.op)
              OP_INIT: begin
                for (int i = 0; i < NREGS; i++) r[i] <= WIDTH'(i);
                ovf_q  <= 1'b0;
                zero_q <= 1'b0;
                err_q  <= 1'b0;
                done_q <= 1'b1;
              end
              OP_CLR: begin
                for (int i = 0; i < NREGS; i++) r[i] <= '0;
                ovf_q  <= 1'b0;
                zero_q <= 1'b1;
                err_q  <= 1'b0;
                done_q <= 1'b1;
              end
              OP_MUL: begin
                state   <= ST_MUL;
                mul_dst <= bus.dst;
              end
              default: begin
                r[bus.dst] <= res;
                ovf_q      <= res_ovf;
                zero_q     <= (res == '0);
                err_q      <= 1'b0;
                done_q     <= 1'b1;
              end
            endcase
          end
        end
      end else if (mul_done) begin
        r[mul_dst] <= prod[WIDTH-1:0];
        ovf_q      <= |prod[2*WIDTH-1:WIDTH];
        zero_q     <= (prod[WIDTH-1:0] == '0);
        err_q      <= 1'b0;
        done_q     <= 1'b1;
        state      <= ST_IDLE;
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign bus.regs[g*WIDTH +: WIDTH] = r[g];
  end

  assign bus.busy = (state == ST_MUL);
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;
  assign bus.err  = err_q;
endmodule

// File: tb/tb_calc_regfile_alu_seq.sv
// tb_calc_regfile_alu_seq: scoreboard bench for calc_regfile_alu_seq (WIDTH=5, NREGS=4).
// The driver issues ops and pushes the expected completion (cycle, registers,
// flags) from an integer reference model; a monitor pops on every done pulse.
module tb_calc_regfile_alu_seq;
  import calc_pkg::*;

  localparam int W = 5;
  localparam int N = 4;
  localparam int M = 32;

  typedef struct {
    int             cyc;
    logic [N*W-1:0] regs;
    logic           ovf;
    logic           zero;
    logic           err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q[$];
  int   m_r[N];
  bit   m_ovf, m_zero;

  calc_regfile_alu_seq_if #(.WIDTH(W), .NREGS(N)) bus();

  calc_regfile_alu_seq #(.WIDTH(W), .NREGS(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compare(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < N; i++) m_r[i] = 0;
    m_ovf  = 1'b0;
    m_zero = 1'b0;
  endtask

  task automatic checkOutput(input exp_t e);
    compare("done_cycle", cyc, e.cyc);
    compare("regs", 32'(bus.regs), 32'(e.regs));
    compare("ovf", 32'(bus.ovf), 32'(e.ovf));
    compare("zero", 32'(bus.zero), 32'(e.zero));
    compare("err", 32'(bus.err), 32'(e.err));
  endtask

  // Issue one op at a negedge once the core is idle; the model is evaluated
  // immediately since the core executes ops strictly in issue order.
  task automatic applyStimulus(input logic [2:0] op, input int d, input int s, input int im);
    int   guard;
    int   a, b, p;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (bus.busy === 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      errors++;
      $display("[TB] FAIL busy_timeout got busy=1 expected busy=0 within 50 cycles");
    end
    bus.start = 1'b1;
    bus.op    = op;
    bus.dst   = 2'(d);
    bus.src   = 2'(s);
    bus.imm   = 5'(im);
    a = m_r[d];
    b = m_r[s];
    case (op)
      OP_INIT: begin
        for (int i = 0; i < N; i++) m_r[i] = i % M;
        m_ovf = 0; m_zero = 0;
      end
      OP_CLR: begin
        for (int i = 0; i < N; i++) m_r[i] = 0;
        m_ovf = 0; m_zero = 1;
      end
      OP_LDI:  begin m_r[d] = im % M; m_ovf = 0; end
      OP_MOV:  begin m_r[d] = b; m_ovf = 0; end
      OP_ADD:  begin m_r[d] = (a + b) % M; m_ovf = (a + b) >= M; end
      OP_SUB:  begin m_r[d] = (a - b + M) % M; m_ovf = a < b; end
      OP_MUL:  begin p = a * b; m_r[d] = p % M; m_ovf = p >= M; end
      default: begin
        if (b < W) begin m_r[d] = 2 ** b; m_ovf = 0; end
        else begin m_r[d] = 0; m_ovf = 1; end
      end
    endcase
    if (op != OP_INIT && op != OP_CLR) m_zero = (m_r[d] == 0);
    e.cyc = cyc + 1 + ((op == OP_MUL) ? W : 0);
    for (int i = 0; i < N; i++) e.regs[i*W +: W] = 5'(m_r[i]);
    e.ovf  = m_ovf;
    e.zero = m_zero;
    e.err  = 1'b0;
    q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done got done=1 expected done=0 at cycle %0d", cyc);
      end else begin
        checkOutput(q.pop_front());
      end
    end
  end

  initial begin
    int nb;
    int guard;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.dst   = '0;
    bus.src   = '0;
    bus.imm   = '0;
    rst_n     = 1'b0;
    modelReset();
    #1;
    compare("reset_regs", 32'(bus.regs), 0);
    compare("reset_busy", 32'(bus.busy), 0);
    compare("reset_done", 32'(bus.done), 0);
    compare("reset_flags", {29'd0, bus.ovf, bus.zero, bus.err}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] directed sequence");

    applyStimulus(OP_INIT, 0, 0, 0);
    applyStimulus(OP_LDI, 1, 0, 20);
    applyStimulus(OP_ADD, 1, 1, 0);
    applyStimulus(OP_INIT, 0, 0, 0);
    applyStimulus(OP_SUB, 0, 3, 0);
    applyStimulus(OP_SUB, 3, 3, 0);

    applyStimulus(OP_LDI, 2, 0, 6);
    applyStimulus(OP_LDI, 3, 0, 7);
    applyStimulus(OP_MUL, 2, 3, 0);
    // Hold a competing request through the busy window; it must be dropped.
    nb = 0;
    bus.start = 1'b1;
    bus.op    = OP_LDI;
    bus.dst   = 2'd0;
    bus.imm   = 5'd31;
    for (int k = 0; k < 12 && bus.busy === 1'b1; k++) begin
      nb++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    compare("mul_busy_cycles", nb, W);

    applyStimulus(OP_LDI, 1, 0, 4);
    applyStimulus(OP_POW2, 0, 1, 0);
    applyStimulus(OP_LDI, 1, 0, 5);
    applyStimulus(OP_POW2, 0, 1, 0);

    // Reset two cycles into a multiply: everything clears, no completion.
    applyStimulus(OP_LDI, 0, 0, 9);
    applyStimulus(OP_MUL, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    modelReset();
    #1;
    compare("midmul_reset_regs", 32'(bus.regs), 0);
    compare("midmul_reset_busy", 32'(bus.busy), 0);
    compare("midmul_reset_done", 32'(bus.done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(OP_LDI, 2, 0, 17);

    $display("[TB] random sequence");
    for (int n = 0; n < 200; n++) begin
      applyStimulus(3'($urandom_range(0, 7)), $urandom_range(0, N-1),
                    $urandom_range(0, N-1), $urandom_range(0, M-1));
    end

    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/calc_regfile_alu_seq.md
Name: calc_regfile_alu_seq

Overview:
- Clocked, parametrised register-file calculator core for the digital calculator datapath: NREGS registers of WIDTH bits, with an 8-op instruction set issued one at a time over a start/busy/done handshake.
- Single-cycle ops for load, move, add, subtract, power-of-two, init and clear; multiply is iterative shift-add over WIDTH cycles.
- Status flags (overflow, zero, error) feed the display and controller logic.

Parameters:
- WIDTH, 5, register and operand width in bits (>=2).
- NREGS, 4, number of registers (>=2).
- IDXW, $clog2(NREGS), localparam, register index width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  issue request; accepted only when busy=0.
- op  input  3  opcode, sampled at accept.
- dst  input  IDXW  destination (and first operand) register index.
- src  input  IDXW  source register index.
- imm  input  WIDTH  immediate for LDI.
- busy  output  1  high while MUL is in progress.
- done  output  1  one-cycle pulse on op completion.
- ovf  output  1  overflow/borrow flag of last completed op.
- zero  output  1  last written result == 0.
- err  output  1  last op had an index >= NREGS (no write performed).
- regs  output  NREGS*WIDTH  flattened register file; R[i] at bits [i*WIDTH +: WIDTH].

Behaviour:
- Reset (async, rst_n=0): all R[i]=0, busy=0, done=0, ovf=0, zero=0, err=0, FSM=IDLE. Reset mid-MUL aborts with no write.
- FSM: IDLE -> MUL on accepted MUL; MUL -> IDLE after WIDTH iterations. All other ops complete within IDLE.
- Accept: rising edge with start=1 and busy=0. start while busy is ignored, with no queueing.
- Single-cycle op accepted at edge t: register file and flags updated at edge t; done=1 for the cycle following edge t.
- MUL accepted at edge t: operands R[dst] and R[src] snapshotted at t (dst==src gives a square). busy=1 for WIDTH cycles. Result written at edge t+WIDTH. done=1 and busy=0 in the following cycle. A new start may be accepted in the done cycle.
- Opcodes (mod 2^WIDTH arithmetic, unsigned):
  - 000 INIT: R[i]=i mod 2^WIDTH for all i; ovf=0, zero=0.
  - 001 LDI: R[dst]=imm; ovf=0.
  - 010 MOV: R[dst]=R[src]; ovf=0.
  - 011 ADD: R[dst]=R[dst]+R[src]; ovf=carry out.
  - 100 SUB: R[dst]=R[dst]-R[src]; ovf=borrow (R[dst]<R[src]).
  - 101 MUL: R[dst]=low WIDTH bits of product; ovf=any high product bit set.
  - 110 POW2: R[dst]=1<<R[src] if R[src]<WIDTH, else 0 with ovf=1.
  - 111 CLR: all R[i]=0; ovf=0, zero=1.
- zero: for single-destination ops, equals (written value==0).
- err: dst or src >= NREGS (possible only when NREGS is not a power of two) → no register write, ovf/zero unchanged, err=1, done still pulses. Otherwise err=0 on each completion.
- Flags hold their value between completions.

Decomposition:
- Package calc_pkg holds:
  - opcode localparams OP_INIT..OP_CLR;
  - FSM state encoding ST_IDLE, ST_MUL.
- Sub-module calc_seq_mul (parameter WIDTH):
  - ports clk, rst_n, go, a, b, busy, done, prod[2*WIDTH-1:0];
  - iterative shift-add, one bit per cycle.
- Top level holds the register file, op decode, flags and handshake.

Test Plan (WIDTH=5, NREGS=4):
- Reset, then INIT → regs R3..R0 = 3,2,1,0; done pulses one cycle after accept; ovf=0.
- LDI dst=1 imm=20, then ADD dst=1 src=1 → R1=8, ovf=1, zero=0.
- After INIT, SUB dst=0 src=3 → R0=29, ovf=1. Then SUB dst=3 src=3 → R3=0, zero=1, ovf=0.
- LDI R2=6, LDI R3=7, MUL dst=2 src=3 accepted at edge t → busy high 5 cycles; start held during busy is ignored; R2=10 at edge t+5; done high in cycle t+6; ovf=1.
- With R1=4, POW2 dst=0 src=1 → R0=16, ovf=0. Then with R1=5 → R0=0, ovf=1, zero=1.
- Assert rst_n=0 two cycles into a MUL → regs all 0 and busy=0 immediately, with no done. After release, LDI is accepted normally.
